// File: rtl/tlul_mon_pkg.sv
// Shared constants for the TL-UL link checker: opcodes, error bit indices and
// small decode helpers.
package tlul_mon_pkg;

   localparam logic [2:0] PUT_FULL        = 3'd0;
   localparam logic [2:0] PUT_PARTIAL     = 3'd1;
   localparam logic [2:0] GET             = 3'd4;
   localparam logic [2:0] ACCESS_ACK      = 3'd0;
   localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

   localparam int ERR_A_UNSTABLE   = 0;
   localparam int ERR_D_UNSTABLE   = 1;
   localparam int ERR_A_BAD_OPCODE = 2;
   localparam int ERR_A_SRC_BUSY   = 3;
   localparam int ERR_D_NO_REQ     = 4;
   localparam int ERR_D_OPCODE     = 5;
   localparam int ERR_D_SIZE       = 6;
   localparam int ERR_TIMEOUT      = 7;
   localparam int NUM_ERR          = 8;

   function automatic logic a_opcode_legal(input logic [2:0] op);
      return (op == PUT_FULL) || (op == PUT_PARTIAL) || (op == GET);
   endfunction

   // Lowest set index wins when several violations appear together.
   function automatic logic [2:0] first_err(input logic [NUM_ERR-1:0] v);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = NUM_ERR - 1; i >= 0; i--) begin
         if (v[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/tlul_src_table.sv
// Per-source outstanding-request table: busy, expect_data and size per source
// ID, with D retirement applied before A allocation in the same cycle.
module tlul_src_table
   import tlul_mon_pkg::*;
#(
   parameter int SRC_WIDTH  = 2,
   parameter int SIZE_WIDTH = 3
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  alloc_i,
   input  logic [SRC_WIDTH-1:0]  alloc_src_i,
   input  logic                  alloc_expect_data_i,
   input  logic [SIZE_WIDTH-1:0] alloc_size_i,
   input  logic                  retire_i,
   input  logic [SRC_WIDTH-1:0]  retire_src_i,
   output logic                  a_busy_o,
   output logic                  d_busy_o,
   output logic                  d_expect_data_o,
   output logic [SIZE_WIDTH-1:0] d_size_o,
   output logic [SRC_WIDTH:0]    outstanding_o
);

   localparam int N = 1 << SRC_WIDTH;

   logic [N-1:0]          busy_q, busy_d;
   logic [N-1:0]          exp_q, exp_d;
   logic [SIZE_WIDTH-1:0] size_q [N];
   logic [SIZE_WIDTH-1:0] size_d [N];

   always_comb begin
      busy_d = busy_q;
      exp_d  = exp_q;
      size_d = size_q;
      if (retire_i) busy_d[retire_src_i] = 1'b0;
      if (alloc_i) begin
         busy_d[alloc_src_i] = 1'b1;
         exp_d[alloc_src_i]  = alloc_expect_data_i;
         size_d[alloc_src_i] = alloc_size_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_q <= '0;
         exp_q  <= '0;
         for (int i = 0; i < N; i++) size_q[i] <= '0;
      end else begin
         busy_q <= busy_d;
         exp_q  <= exp_d;
         size_q <= size_d;
      end
   end

   // A source freed by this cycle's D beat counts as free for the A side.
   assign a_busy_o        = busy_q[alloc_src_i] & ~(retire_i && (retire_src_i == alloc_src_i));
   assign d_busy_o        = busy_q[retire_src_i];
   assign d_expect_data_o = exp_q[retire_src_i];
   assign d_size_o        = size_q[retire_src_i];

   always_comb begin
      outstanding_o = '0;
      for (int i = 0; i < N; i++) outstanding_o = outstanding_o + {{SRC_WIDTH{1'b0}}, busy_q[i]};
   end

endmodule

// File: rtl/tlul_link_checker.sv
// Passive TL-UL A/D link checker: stability, pairing, opcode, size and timeout
// violations latched as sticky bits, plus saturating beat counters.
module tlul_link_checker
   import tlul_mon_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int MASK_WIDTH     = DATA_WIDTH / 8,
   parameter int SIZE_WIDTH     = 3,
   parameter int SRC_WIDTH      = 2,
   parameter int SINK_WIDTH     = 1,
   parameter int CNT_WIDTH      = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk_24,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  a_valid,
   input  logic                  a_ready,
   input  logic [2:0]            a_opcode,
   input  logic [2:0]            a_param,
   input  logic [SIZE_WIDTH-1:0] a_size,
   input  logic [SRC_WIDTH-1:0]  a_source,
   input  logic [ADDR_WIDTH-1:0] a_address,
   input  logic [MASK_WIDTH-1:0] a_mask,
   input  logic [DATA_WIDTH-1:0] a_data,
   input  logic                  d_valid,
   input  logic                  d_ready,
   input  logic [2:0]            d_opcode,
   input  logic [2:0]            d_param,
   input  logic [SIZE_WIDTH-1:0] d_size,
   input  logic [SRC_WIDTH-1:0]  d_source,
   input  logic [SINK_WIDTH-1:0] d_sink,
   input  logic [DATA_WIDTH-1:0] d_data,
   input  logic                  d_error,
   output logic [7:0]            err_flags,
   output logic                  err_valid,
   output logic [2:0]            err_code,
   output logic [CNT_WIDTH-1:0]  a_count,
   output logic [CNT_WIDTH-1:0]  d_count,
   output logic [SRC_WIDTH:0]    outstanding
);

   localparam int A_PL_W = 6 + SIZE_WIDTH + SRC_WIDTH + ADDR_WIDTH + MASK_WIDTH + DATA_WIDTH;
   localparam int D_PL_W = 7 + SIZE_WIDTH + SRC_WIDTH + SINK_WIDTH + DATA_WIDTH;
   localparam int WD_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0]      WD_MAX  = WD_W'(TIMEOUT_CYCLES);
   localparam logic [WD_W-1:0]      WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   logic a_fire, d_fire, a_op_ok;
   logic [A_PL_W-1:0] a_pl, a_pl_q;
   logic [D_PL_W-1:0] d_pl, d_pl_q;
   logic a_stall_q, d_stall_q;

   logic                  tbl_a_busy, tbl_d_busy, tbl_d_exp;
   logic [SIZE_WIDTH-1:0] tbl_d_size;

   logic [WD_W-1:0]      wd_q, wd_d;
   logic                 wd_idle, wd_hit;
   logic [CNT_WIDTH-1:0] a_count_q, a_count_d, d_count_q, d_count_d;
   logic [7:0]           viol, err_flags_q, err_flags_d;
   logic                 err_valid_q, err_valid_d;
   logic [2:0]           err_code_q, err_code_d;

   assign a_fire  = a_valid & a_ready;
   assign d_fire  = d_valid & d_ready;
   assign a_op_ok = a_opcode_legal(a_opcode);
   assign a_pl    = {a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data};
   assign d_pl    = {d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error};

   tlul_src_table #(
      .SRC_WIDTH (SRC_WIDTH),
      .SIZE_WIDTH(SIZE_WIDTH)
   ) u_table (
      .clk_i              (clk_24),
      .rst_ni             (reset),
      .alloc_i            (a_fire & a_op_ok),
      .alloc_src_i        (a_source),
      .alloc_expect_data_i(a_opcode == GET),
      .alloc_size_i       (a_size),
      .retire_i           (d_fire & tbl_d_busy),
      .retire_src_i       (d_source),
      .a_busy_o           (tbl_a_busy),
      .d_busy_o           (tbl_d_busy),
      .d_expect_data_o    (tbl_d_exp),
      .d_size_o           (tbl_d_size),
      .outstanding_o      (outstanding)
   );

   // Watchdog only runs while something is outstanding and no D beat lands.
   assign wd_idle = d_fire | (outstanding == '0);
   assign wd_hit  = ~wd_idle & (wd_q == WD_LAST);

   always_comb begin
      wd_d = wd_q;
      if (clear || wd_idle)   wd_d = '0;
      else if (wd_q != WD_MAX) wd_d = wd_q + 1'b1;
   end

   always_comb begin
      viol = '0;
      viol[ERR_A_UNSTABLE]   = a_stall_q & (~a_valid | (a_pl != a_pl_q));
      viol[ERR_D_UNSTABLE]   = d_stall_q & (~d_valid | (d_pl != d_pl_q));
      viol[ERR_A_BAD_OPCODE] = a_fire & ~a_op_ok;
      viol[ERR_A_SRC_BUSY]   = a_fire & a_op_ok & tbl_a_busy;
      viol[ERR_D_NO_REQ]     = d_fire & ~tbl_d_busy;
      viol[ERR_D_OPCODE]     = d_fire & tbl_d_busy &
                               (d_opcode != (tbl_d_exp ? ACCESS_ACK_DATA : ACCESS_ACK));
      viol[ERR_D_SIZE]       = d_fire & tbl_d_busy & (d_size != tbl_d_size);
      viol[ERR_TIMEOUT]      = wd_hit;
   end

   always_comb begin
      err_flags_d = err_flags_q | viol;
      err_valid_d = |(viol & ~err_flags_q);
      err_code_d  = err_code_q;
      if (err_flags_q == '0 && viol != '0) err_code_d = first_err(viol);
      a_count_d = a_count_q;
      d_count_d = d_count_q;
      if (a_fire && a_count_q != CNT_MAX) a_count_d = a_count_q + 1'b1;
      if (d_fire && d_count_q != CNT_MAX) d_count_d = d_count_q + 1'b1;
      if (clear) begin
         err_flags_d = '0;
         err_valid_d = 1'b0;
         err_code_d  = '0;
         a_count_d   = '0;
         d_count_d   = '0;
      end
   end

   always_ff @(posedge clk_24 or negedge reset) begin
      if (!reset) begin
         a_stall_q   <= 1'b0;
         d_stall_q   <= 1'b0;
         a_pl_q      <= '0;
         d_pl_q      <= '0;
         wd_q        <= '0;
         err_flags_q <= '0;
         err_valid_q <= 1'b0;
         err_code_q  <= '0;
         a_count_q   <= '0;
         d_count_q   <= '0;
      end else begin
         a_stall_q   <= a_valid & ~a_ready;
         d_stall_q   <= d_valid & ~d_ready;
         a_pl_q      <= a_pl;
         d_pl_q      <= d_pl;
         wd_q        <= wd_d;
         err_flags_q <= err_flags_d;
         err_valid_q <= err_valid_d;
         err_code_q  <= err_code_d;
         a_count_q   <= a_count_d;
         d_count_q   <= d_count_d;
      end
   end

   assign err_flags = err_flags_q;
   assign err_valid = err_valid_q;
   assign err_code  = err_code_q;
   assign a_count   = a_count_q;
   assign d_count   = d_count_q;

endmodule

// File: tb/tb_tlul_link_checker.sv
// Directed bench for tlul_link_checker: expected error events queued by the
// stimulus, popped by a monitor on every err_valid pulse.
module tb_tlul_link_checker;

   logic        clk_24 = 1'b0;
   logic        reset, clear;
   logic        a_valid, a_ready, d_valid, d_ready, d_error;
   logic [2:0]  a_opcode, a_param, a_size, d_opcode, d_param, d_size;
   logic [1:0]  a_source, d_source;
   logic [31:0] a_address, a_data, d_data;
   logic [3:0]  a_mask;
   logic [0:0]  d_sink;
   logic [7:0]  err_flags;
   logic        err_valid;
   logic [2:0]  err_code;
   logic [3:0]  a_count, d_count;
   logic [2:0]  outstanding;

   logic [10:0] exp_q[$];
   int total = 0;
   int bad   = 0;

   tlul_link_checker #(.CNT_WIDTH(4), .TIMEOUT_CYCLES(16)) dut (
      .clk_24(clk_24), .reset(reset), .clear(clear),
      .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
      .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
      .a_data(a_data), .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode),
      .d_param(d_param), .d_size(d_size), .d_source(d_source), .d_sink(d_sink),
      .d_data(d_data), .d_error(d_error), .err_flags(err_flags), .err_valid(err_valid),
      .err_code(err_code), .a_count(a_count), .d_count(d_count), .outstanding(outstanding)
   );

   always #5 clk_24 = ~clk_24;

   // Monitor: every err_valid pulse must match the next queued event.
   always @(negedge clk_24) begin
      if (reset && err_valid) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL err_event: unexpected pulse flags=%h code=%0d", err_flags, err_code);
         end else begin
            logic [10:0] e;
            e = exp_q.pop_front();
            if ({err_flags, err_code} !== e) begin
               bad++;
               $display("FAIL err_event: got flags=%h code=%0d want flags=%h code=%0d",
                        err_flags, err_code, e[10:3], e[2:0]);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk_24);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, want);
      end
   endtask

   task automatic idle();
      a_valid = 1'b0; a_ready = 1'b1; d_valid = 1'b0; d_ready = 1'b1;
   endtask

   task automatic set_a(input logic [2:0] op, input logic [2:0] sz, input logic [1:0] src,
                        input logic [31:0] addr);
      a_valid = 1'b1; a_opcode = op; a_size = sz; a_source = src; a_address = addr;
   endtask

   task automatic set_d(input logic [2:0] op, input logic [2:0] sz, input logic [1:0] src,
                        input logic [31:0] data);
      d_valid = 1'b1; d_opcode = op; d_size = sz; d_source = src; d_data = data;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_flags"}, 32'(err_flags), 32'h0);
      check({tag, "_valid"}, 32'(err_valid), 32'h0);
      check({tag, "_code"}, 32'(err_code), 32'h0);
      check({tag, "_acnt"}, 32'(a_count), 32'h0);
      check({tag, "_dcnt"}, 32'(d_count), 32'h0);
      check({tag, "_outst"}, 32'(outstanding), 32'h0);
   endtask

   initial begin
      reset = 1'b0; clear = 1'b0;
      idle();
      a_opcode = 3'd0; a_param = 3'd0; a_size = 3'd2; a_source = 2'd0;
      a_address = 32'h0; a_mask = 4'hf; a_data = 32'h0;
      d_opcode = 3'd0; d_param = 3'd0; d_size = 3'd2; d_source = 2'd0;
      d_sink = 1'b0; d_data = 32'h0; d_error = 1'b0;
      repeat (3) @(posedge clk_24);
      #1 reset = 1'b1;
      check_all_zero("reset");

      // Clean Get / AccessAckData on source 1
      set_a(3'd4, 3'd2, 2'd1, 32'h40); tick(); idle();
      check("get_outst", 32'(outstanding), 32'd1);
      check("get_acnt", 32'(a_count), 32'd1);
      set_d(3'd1, 3'd2, 2'd1, 32'hdead); tick(); idle();
      check("ack_dcnt", 32'(d_count), 32'd1);
      check("ack_outst", 32'(outstanding), 32'd0);
      check("ack_flags", 32'(err_flags), 32'h0);

      // A payload changes while stalled
      a_ready = 1'b0; set_a(3'd0, 3'd2, 2'd0, 32'h100);
      tick(); tick();
      check("stall_ok_flags", 32'(err_flags), 32'h0);
      exp_q.push_back({8'h01, 3'd0});
      a_address = 32'h104; tick();
      idle(); tick();
      check("a_unstable_flags", 32'(err_flags), 32'h01);
      check("a_unstable_code", 32'(err_code), 32'd0);
      do_clear();
      check("clear_flags", 32'(err_flags), 32'h0);

      // D on idle source, then wrong D opcode for a Get
      exp_q.push_back({8'h10, 3'd4});
      set_d(3'd0, 3'd2, 2'd3, 32'h0); tick(); idle();
      set_a(3'd4, 3'd2, 2'd2, 32'h80); tick(); idle();
      exp_q.push_back({8'h30, 3'd4});
      set_d(3'd0, 3'd2, 2'd2, 32'h0); tick(); idle();
      check("dop_flags", 32'(err_flags), 32'h30);
      check("dop_code", 32'(err_code), 32'd4);
      check("dop_outst", 32'(outstanding), 32'd0);
      do_clear();

      // D size mismatch
      set_a(3'd4, 3'd2, 2'd1, 32'h0); tick(); idle();
      exp_q.push_back({8'h40, 3'd6});
      set_d(3'd1, 3'd1, 2'd1, 32'h0); tick(); idle();
      check("dsize_code", 32'(err_code), 32'd6);
      do_clear();

      // Illegal A opcode never allocates
      exp_q.push_back({8'h04, 3'd2});
      set_a(3'd2, 3'd2, 2'd0, 32'h0); tick(); idle();
      check("badop_outst", 32'(outstanding), 32'd0);
      do_clear();

      // Second request on a busy source
      set_a(3'd4, 3'd2, 2'd3, 32'h0); tick();
      exp_q.push_back({8'h08, 3'd3});
      tick(); idle();
      check("busy_outst", 32'(outstanding), 32'd1);
      set_d(3'd1, 3'd2, 2'd3, 32'h0); tick(); idle();
      check("busy_retired", 32'(outstanding), 32'd0);
      do_clear();

      // D payload changes while stalled
      d_ready = 1'b0; set_d(3'd0, 3'd2, 2'd0, 32'h11); tick();
      exp_q.push_back({8'h02, 3'd1});
      d_data = 32'h22; tick();
      idle(); tick();
      check("d_unstable_code", 32'(err_code), 32'd1);
      do_clear();

      // Watchdog: flag lands exactly 16 edges after the Get
      exp_q.push_back({8'h80, 3'd7});
      set_a(3'd4, 3'd2, 2'd0, 32'h0); tick(); idle();
      repeat (15) tick();
      check("wd_before", 32'(err_flags), 32'h0);
      tick();
      check("wd_hit", 32'(err_flags), 32'h80);
      check("wd_code", 32'(err_code), 32'd7);
      set_d(3'd1, 3'd2, 2'd0, 32'h0); tick(); idle();
      do_clear();

      // Same-cycle retire and reallocate of source 2
      set_a(3'd4, 3'd2, 2'd2, 32'h0); tick(); idle();
      set_d(3'd1, 3'd2, 2'd2, 32'h0); set_a(3'd4, 3'd2, 2'd2, 32'h4); tick(); idle();
      check("same_outst", 32'(outstanding), 32'd1);
      check("same_flags", 32'(err_flags), 32'h0);
      set_d(3'd1, 3'd2, 2'd2, 32'h0); tick(); idle();
      exp_q.push_back({8'h10, 3'd4});
      set_d(3'd1, 3'd2, 2'd2, 32'h0); set_a(3'd4, 3'd2, 2'd2, 32'h8); tick(); idle();
      check("idle_same_flags", 32'(err_flags), 32'h10);
      check("idle_same_outst", 32'(outstanding), 32'd1);
      set_d(3'd1, 3'd2, 2'd2, 32'h0); tick(); idle();
      do_clear();

      // 19 A fires and 19 D fires saturate the 4-bit counters
      set_a(3'd0, 3'd2, 2'd0, 32'h0); tick();
      set_d(3'd0, 3'd2, 2'd0, 32'h0);
      repeat (18) tick();
      a_valid = 1'b0; tick(); idle();
      check("sat_acnt", 32'(a_count), 32'd15);
      check("sat_dcnt", 32'(d_count), 32'd15);
      check("sat_flags", 32'(err_flags), 32'h0);
      check("sat_outst", 32'(outstanding), 32'd0);
      do_clear();
      check("clr_acnt", 32'(a_count), 32'd0);
      check("clr_dcnt", 32'(d_count), 32'd0);

      // Reset mid-request drops the table
      set_a(3'd4, 3'd2, 2'd1, 32'h0); tick(); idle();
      check("pre_rst_outst", 32'(outstanding), 32'd1);
      reset = 1'b0; #2;
      check("async_rst_outst", 32'(outstanding), 32'd0);
      tick(); tick();
      reset = 1'b1;
      check_all_zero("midrst");
      exp_q.push_back({8'h10, 3'd4});
      set_d(3'd1, 3'd2, 2'd1, 32'h0); tick(); idle();
      check("post_rst_flags", 32'(err_flags), 32'h10);

      repeat (3) tick();
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
